// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 raster constants, counter widths and window helpers.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package vga_timing_pkg;

  localparam int COUNT_W = 10;
  // Enough bits for the largest legal divider (16 clocks per pixel).
  localparam int DIV_W   = 4;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  localparam int H_TOTAL_640 = H_ACTIVE_640 + H_FP_640 + H_SYNC_640 + H_BP_640;
  localparam int V_TOTAL_480 = V_ACTIVE_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

  // Sync windows are half-open: start inclusive, end exclusive.
  localparam int HS_START_640 = H_ACTIVE_640 + H_FP_640;
  localparam int HS_END_640   = HS_START_640 + H_SYNC_640;
  localparam int VS_START_480 = V_ACTIVE_480 + V_FP_480;
  localparam int VS_END_480   = VS_START_480 + V_SYNC_480;

  // True when lo <= v < hi, all 10-bit unsigned.
  function automatic logic in_window(input logic [COUNT_W-1:0] v,
                                     input logic [COUNT_W-1:0] lo,
                                     input logic [COUNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// Purpose: divides the system clock into a one-clk pixel enable every PIX_DIV clks.
// Latency: first pixpulse PIX_DIV clks after reset release, registered output.
// Backpressure: none; free-running source.
module pix_ce_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pixpulse
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div;

  // Phase counter wraps at PIX_DIV-1; the pulse is the registered terminal-count decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      pixpulse <= 1'b0;
    end else begin
      pixpulse <= (div == DIV_LAST);
      div      <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: raster-scan timing source (counts, syncs, video_on, frame_end); VGA_SYNC_DELAY_EN adds a sync/video delay line.
// Latency: syncs/video_on zero skew to counts (or SYNC_DLY pixels late with VGA_SYNC_DELAY_EN).
// Backpressure: none; sinks must keep up with the pixel rate.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int V_ACTIVE = V_ACTIVE_480,
  parameter int V_FP     = V_FP_480,
  parameter int V_SYNC   = V_SYNC_480,
  parameter int V_BP     = V_BP_480,
  parameter bit SYNC_POL = 1'b0,
  parameter int SYNC_DLY = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pixpulse,
  output logic [COUNT_W-1:0] hcount,
  output logic [COUNT_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_end
);

  localparam logic [COUNT_W-1:0] H_MAX = COUNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COUNT_W-1:0] V_MAX = COUNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COUNT_W-1:0] H_VIS = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_VIS = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] HS_LO = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] HS_HI = COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNT_W-1:0] VS_LO = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] VS_HI = COUNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic               SYNC_IDLE = ~SYNC_POL;

  logic               h_wrap;
  logic               v_wrap;
  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_next;
  logic               hs_raw;
  logic               vs_raw;
  logic               vid_raw;

  pix_ce_gen #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_ce (
    .clk      (clk),
    .rst      (rst),
    .pixpulse (pixpulse)
  );

  // Next raster position; equality compares so counts can never run past the totals.
  always_comb begin
    h_wrap = (hcount == H_MAX);
    v_wrap = (vcount == V_MAX);
    h_next = h_wrap ? '0 : hcount + COUNT_W'(1);
    v_next = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + COUNT_W'(1);
    end
  end

  // Counters and decodes share one register stage, so syncs have zero skew to the counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount    <= '0;
      vcount    <= '0;
      hs_raw    <= SYNC_IDLE;
      vs_raw    <= SYNC_IDLE;
      vid_raw   <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      frame_end <= pixpulse && h_wrap && v_wrap;
      if (pixpulse) begin
        hcount  <= h_next;
        vcount  <= v_next;
        hs_raw  <= in_window(h_next, HS_LO, HS_HI) ? SYNC_POL : SYNC_IDLE;
        vs_raw  <= in_window(v_next, VS_LO, VS_HI) ? SYNC_POL : SYNC_IDLE;
        vid_raw <= (h_next < H_VIS) && (v_next < V_VIS);
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DLY-1:0] hs_sr;
  logic [SYNC_DLY-1:0] vs_sr;
  logic [SYNC_DLY-1:0] vid_sr;

  // Pixel-rate delay line matching the registered glyph/ROM lookup in the renderers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sr  <= {SYNC_DLY{SYNC_IDLE}};
      vs_sr  <= {SYNC_DLY{SYNC_IDLE}};
      vid_sr <= '0;
    end else if (pixpulse) begin
      hs_sr[0]  <= hs_raw;
      vs_sr[0]  <= vs_raw;
      vid_sr[0] <= vid_raw;
      for (int i = 1; i < SYNC_DLY; i++) begin
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
        vid_sr[i] <= vid_sr[i-1];
      end
    end
  end

  assign hsync    = hs_sr[SYNC_DLY-1];
  assign vsync    = vs_sr[SYNC_DLY-1];
  assign video_on = vid_sr[SYNC_DLY-1];
`else
  // Delay depth only matters when the delay line is built.
  wire unused_sync_dly = (SYNC_DLY != 0);

  assign hsync    = hs_raw;
  assign vsync    = vs_raw;
  assign video_on = vid_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instance for divider, line and reset checks,
// plus a shrunken 16x12 raster instance so whole frames fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_b;

  logic       pp_a, hs_a, vs_a, vo_a, fe_a;
  logic [9:0] hc_a, vc_a;
  logic       pp_b, hs_b, vs_b, vo_b, fe_b;
  logic [9:0] hc_b, vc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk       (clk),
    .rst       (rst_a),
    .pixpulse  (pp_a),
    .hcount    (hc_a),
    .vcount    (vc_a),
    .hsync     (hs_a),
    .vsync     (vs_a),
    .video_on  (vo_a),
    .frame_end (fe_a)
  );

  // 16 x 12 total raster: H 8/2/3/3, V 6/2/2/2, 2 clks per pixel.
  vga_timing_gen #(
    .PIX_DIV  (2),
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b0),
    .SYNC_DLY (1)
  ) u_b (
    .clk       (clk),
    .rst       (rst_b),
    .pixpulse  (pp_b),
    .hcount    (hc_b),
    .vcount    (vc_b),
    .hsync     (hs_b),
    .vsync     (vs_b),
    .video_on  (vo_b),
    .frame_end (fe_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  int hs_cnt, hs_first, hs_last;
  int vid_cnt, vs_cnt, vs_min, vs_max, pix_cnt;
  int fe_cnt, fe_k, fe_h, fe_v, h_max, v_max;
  logic vid_in, vid_out, v1, v2, v3;
  logic done;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_pixpulse", 32'(pp_a), 0);
    chk("rst_hcount", 32'(hc_a), 0);
    chk("rst_vcount", 32'(vc_a), 0);
    chk("rst_hsync", 32'(hs_a), 1);
    chk("rst_vsync", 32'(vs_a), 1);
    chk("rst_video_on", 32'(vo_a), (DLY == 0) ? 1 : 0);
    chk("rst_frame_end", 32'(fe_a), 0);
    chk("rst_b_hcount", 32'(hc_b), 0);

    // Divider phase after release: pulse on the 4th clk, then every 4
    rst_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pix_quiet", 32'(pp_a), 0);
    end
    @(negedge clk);
    chk("pix_first", 32'(pp_a), 1);
    chk("pix_first_hcount", 32'(hc_a), 0);
    @(negedge clk);
    chk("pix_single_clk", 32'(pp_a), 0);
    chk("hcount_step", 32'(hc_a), 1);
    repeat (2) @(negedge clk);
    chk("pix_gap", 32'(pp_a), 0);
    @(negedge clk);
    chk("pix_second", 32'(pp_a), 1);

    // One line: hsync window and video_on edge
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    vid_in = 1'bx; vid_out = 1'bx; done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (pp_a) begin
        if (hs_a == 1'b0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(hc_a);
          hs_last = int'(hc_a);
        end
        if (int'(hc_a) == 639 + DLY) vid_in = vo_a;
        if (int'(hc_a) == 640 + DLY) vid_out = vo_a;
        if (hc_a == 10'd799) done = 1'b1;
      end
    end
    chk("line_end_reached", 32'(done), 1);
    chk("hsync_width", 32'(hs_cnt), 96);
    chk("hsync_first", 32'(hs_first), 656 + DLY);
    chk("hsync_last", 32'(hs_last), 751 + DLY);
    chk("video_on_639", 32'(vid_in), 1);
    chk("video_on_640", 32'(vid_out), 0);
    @(negedge clk);
    chk("line_wrap_hcount", 32'(hc_a), 0);
    chk("line_wrap_vcount", 32'(vc_a), 1);
    chk("line_wrap_hsync", 32'(hs_a), 1);
    chk("line_wrap_video_on", 32'(vo_a), (DLY == 0) ? 1 : 0);
    chk("line_wrap_no_frame_end", 32'(fe_a), 0);

    // Mid-frame reset at (300,1): outputs clear asynchronously
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (hc_a == 10'd300 && vc_a == 10'd1) done = 1'b1;
    end
    chk("reach_300_1", 32'(done), 1);
    rst_a = 1'b1;
    #1;
    chk("midrst_hcount", 32'(hc_a), 0);
    chk("midrst_vcount", 32'(vc_a), 0);
    chk("midrst_pixpulse", 32'(pp_a), 0);
    chk("midrst_hsync", 32'(hs_a), 1);
    chk("midrst_vsync", 32'(vs_a), 1);
    chk("midrst_video_on", 32'(vo_a), (DLY == 0) ? 1 : 0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("restart_quiet", 32'(pp_a), 0);
    end
    @(negedge clk);
    chk("restart_pix", 32'(pp_a), 1);
    chk("restart_hcount", 32'(hc_a), 0);
    chk("restart_vcount", 32'(vc_a), 0);
    @(negedge clk);
    chk("restart_step", 32'(hc_a), 1);
    rst_a = 1'b1;

    // Whole frame on the small raster
    pix_cnt = 0; vid_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    vs_min = 1000; vs_max = -1; fe_cnt = 0; fe_k = -1; fe_h = -1; fe_v = -1;
    h_max = 0; v_max = 0;
    v1 = 1'bx; v2 = 1'bx; v3 = 1'bx;
    rst_b = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (int'(hc_b) > h_max) h_max = int'(hc_b);
      if (int'(vc_b) > v_max) v_max = int'(vc_b);
      if (k <= 384 && pp_b) begin
        pix_cnt++;
        if (vo_b) vid_cnt++;
        if (!hs_b) hs_cnt++;
        if (!vs_b) begin
          vs_cnt++;
          if (int'(vc_b) < vs_min) vs_min = int'(vc_b);
          if (int'(vc_b) > vs_max) vs_max = int'(vc_b);
        end
        if (int'(hc_b) == 7 + DLY && vc_b == 10'd5) v1 = vo_b;
        if (int'(hc_b) == 8 + DLY && vc_b == 10'd0) v2 = vo_b;
        if (int'(hc_b) == DLY && vc_b == 10'd6) v3 = vo_b;
      end
      if (fe_b) begin
        fe_cnt++;
        fe_k = k;
        fe_h = int'(hc_b);
        fe_v = int'(vc_b);
      end
    end
    chk("frame_pixpulses", 32'(pix_cnt), 192);
    chk("frame_video_on", 32'(vid_cnt), 48);
    chk("frame_hsync_pix", 32'(hs_cnt), 36);
    chk("frame_vsync_pix", 32'(vs_cnt), 32);
    chk("vsync_first_line", 32'(vs_min), 8);
    chk("vsync_last_line", 32'(vs_max), 9 + DLY);
    chk("video_on_last_vis", 32'(v1), 1);
    chk("video_on_right", 32'(v2), 0);
    chk("video_on_below", 32'(v3), 0);
    chk("frame_end_count", 32'(fe_cnt), 1);
    chk("frame_end_clk", 32'(fe_k), 385);
    chk("frame_end_hcount", 32'(fe_h), 0);
    chk("frame_end_vcount", 32'(fe_v), 0);
    chk("hcount_max", 32'(h_max), 15);
    chk("vcount_max", 32'(v_max), 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
